bram_stream_reader: RTL and testbench

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

---
 rtl/bram_stream_reader.sv | 161 ++++++++++++++++
 tb/tb_bram_stream_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Streams a contiguous block of BRAM words out over a valid/ready interface.
// A small 4-entry FIFO absorbs the one-cycle BRAM read latency under backpressure.
`timescale 1ns/1ps
module bram_stream_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    input  logic [DATA_W-1:0] bram_do,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    logic              bram_en_r;
    logic              inflight_r;
    logic              done_r;
    logic [ADDR_W-1:0] bram_addr_r;
    logic [ADDR_W-1:0] reads_left_r;
    logic [ADDR_W-1:0] out_left_r;
    logic [DATA_W-1:0] fifo_mem_r [4];
    logic [1:0]        wr_ptr_r;
    logic [1:0]        rd_ptr_r;
    logic [2:0]        count_r;

    logic              m_valid_s;
    logic              m_last_s;
    logic              push_s;
    logic              pop_s;
    logic [2:0]        count_next_s;
    logic [3:0]        occupancy_s;
    logic [ADDR_W-1:0] reads_after_s;
    logic              issue_next_s;

    assign m_valid_s = (count_r != 3'd0);
    assign m_last_s  = m_valid_s & (out_left_r == ADDR_W'(1));

    // Next-cycle read decision: counts the data landing next cycle so the FIFO can never overflow.
    always_comb begin
        push_s        = inflight_r;
        pop_s         = m_valid_s & m_ready;
        count_next_s  = count_r + {2'b00, push_s} - {2'b00, pop_s};
        occupancy_s   = {1'b0, count_next_s} + {3'b000, bram_en_r};
        reads_after_s = reads_left_r;
        issue_next_s  = 1'b0;
        if (bram_en_r) begin
            reads_after_s = reads_left_r - ADDR_W'(1);
        end else begin
            reads_after_s = reads_left_r;
        end
        if ((state_r == READ) && (reads_after_s != '0) && (occupancy_s <= 4'd2)) begin
            issue_next_s = 1'b1;
        end else begin
            issue_next_s = 1'b0;
        end
    end

    // FIFO storage; contents are don't-care whenever count_r says the slot is empty.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= bram_do;
        end
    end

    // Control FSM, read issue and FIFO pointer bookkeeping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            bram_en_r    <= 1'b0;
            inflight_r   <= 1'b0;
            done_r       <= 1'b0;
            bram_addr_r  <= '0;
            reads_left_r <= '0;
            out_left_r   <= '0;
            wr_ptr_r     <= 2'd0;
            rd_ptr_r     <= 2'd0;
            count_r      <= 3'd0;
        end else begin
            inflight_r <= bram_en_r;
            count_r    <= count_next_s;
            done_r     <= 1'b0;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + 2'd1;
                out_left_r <= out_left_r - ADDR_W'(1);
            end
            if (bram_en_r) begin
                bram_addr_r <= bram_addr_r + ADDR_W'(1);
            end
            case (state_r)
                IDLE: begin
                    bram_en_r <= 1'b0;
                    if (start) begin
                        if (length != '0) begin
                            bram_addr_r  <= base_addr;
                            reads_left_r <= length;
                            out_left_r   <= length;
                            bram_en_r    <= 1'b1;
                            state_r      <= READ;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                READ: begin
                    reads_left_r <= reads_after_s;
                    bram_en_r    <= issue_next_s;
                    if (reads_after_s == '0) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    bram_en_r <= 1'b0;
                    if (pop_s && m_last_s) begin
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    bram_en_r <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    bram_en_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign bram_en   = bram_en_r;
    assign bram_addr = bram_addr_r;
    assign bram_we   = 1'b0;
    assign m_valid   = m_valid_s;
    assign m_last    = m_last_s;
    assign m_data    = m_valid_s ? fifo_mem_r[rd_ptr_r] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed and randomized bursts against a queue-based reference of the expected stream.
`timescale 1ns/1ps
module tb_bram_stream_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base_addr = 11'd0;
    logic [10:0] length = 11'd0;
    logic        busy, done, bram_en, bram_we, m_valid, m_last;
    logic [10:0] bram_addr;
    logic [7:0]  bram_do = 8'd0;
    logic [7:0]  m_data;
    logic        m_ready = 1'b1;

    bram_stream_reader #(.ADDR_W(11), .DATA_W(8)) dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_we(bram_we), .bram_do(bram_do), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem [2048];

    // BRAM with one-cycle read latency
    always @(posedge CLK) begin
        if (bram_en) bram_do <= mem[bram_addr];
    end

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q [$];
    int cyc_n, base_r, n_reads, first_en, last_en, first_valid, last_cyc, done_cyc, n_done;
    int reads_at8;
    logic busy1;
    logic hold_v, hold_l;
    logic [7:0] hold_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic observe();
        logic [8:0] e;
        chk("bram_we", bram_we, 0);
        if (bram_en) begin
            chk("rd_addr", bram_addr, (base_r + n_reads) % 2048);
            if (first_en < 0) first_en = cyc_n;
            last_en = cyc_n;
            n_reads++;
        end
        if (hold_v) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, hold_d);
            chk("hold_last", m_last, hold_l);
        end
        hold_v = m_valid & ~m_ready;
        hold_d = m_data;
        hold_l = m_last;
        if (m_valid && first_valid < 0) first_valid = cyc_n;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_elem", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", m_data, e[7:0]);
                chk("last", m_last, e[8]);
                if (m_last) last_cyc = cyc_n;
            end
        end
        if (done) begin
            n_done++;
            done_cyc = cyc_n;
        end
        if (cyc_n == 1) busy1 = busy;
    endtask

    task automatic tick(input logic st, input logic rdy, input logic rs);
        @(negedge CLK);
        start = st;
        m_ready = rdy;
        RST = rs;
        #1;
        observe();
        cyc_n++;
    endtask

    task automatic setup(input int base, input int len);
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, mem[(base + i) % 2048]});
        base_r = base; n_reads = 0; first_en = -1; last_en = -1; first_valid = -1;
        last_cyc = -1; done_cyc = -1; n_done = 0; cyc_n = 0; reads_at8 = -1;
        hold_v = 1'b0; busy1 = 1'b0;
        base_addr = 11'(base);
        length = 11'(len);
    endtask

    // mode 0: ready high, 1: ready low cycles 3-8, 2: random ready, 3: extra start at cycle 2
    task automatic run_burst(input int base, input int len, input int mode);
        logic rdy, st;
        setup(base, len);
        tick(1'b1, 1'b1, 1'b0);
        while (cyc_n < 300 && !(done_cyc >= 0 && cyc_n > done_cyc + 1)) begin
            st = 1'b0;
            rdy = 1'b1;
            if (mode == 1) rdy = !(cyc_n >= 3 && cyc_n <= 8);
            if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 3 && cyc_n == 2) begin
                st = 1'b1;
                base_addr = 11'd100;
            end
            tick(st, rdy, 1'b0);
            if (cyc_n == 9) reads_at8 = n_reads;
        end
        if (done_cyc < 0) chk("timeout", 0, 1);
        chk("n_reads", n_reads, len);
        chk("left_over", exp_q.size(), 0);
        chk("n_done", n_done, 1);
        chk("idle_after", busy, 0);
        if (mode == 0 && len > 0) begin
            chk("first_en", first_en, 1);
            chk("last_en", last_en, len);
            chk("first_valid", first_valid, 3);
            chk("last_cyc", last_cyc, len + 2);
            chk("done_cyc", done_cyc, len + 3);
        end
        if (mode == 1) chk("reads_by_8", reads_at8, 3);
        if (len == 0) begin
            chk("zero_done_cyc", done_cyc, 1);
            chk("zero_busy1", busy1, 1);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_en"}, bram_en, 0);
        chk({tag, "_addr"}, bram_addr, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_data"}, m_data, 0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        mem[0] = 8'd11; mem[1] = 8'd22; mem[2] = 8'd33; mem[3] = 8'd44;

        // reset wins over a simultaneous start
        setup(7, 5);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check_quiet("rst");
        tick(1'b0, 1'b1, 1'b0);
        chk("rst_start_ignored", busy, 0);

        run_burst(0, 4, 0);
        run_burst(0, 4, 1);
        run_burst(2046, 3, 0);
        run_burst(5, 0, 0);
        run_burst(0, 4, 3);

        // reset in cycle 4 of a length-8 burst, then a fresh length-2 burst
        setup(10, 8);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        check_quiet("midrst");
        run_burst(600, 2, 0);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
            run_burst($urandom_range(0, 2047), $urandom_range(1, 20), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
